// File: rtl/stream_serialize.sv
// Parallel-to-stream converter: accepts one LENGTH-element vector per handshake
// and emits it as a contiguous LENGTH-beat burst, chaining vectors without bubbles.
module stream_serialize #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned LENGTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LENGTH*BITS-1:0]   a,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic [BITS-1:0]          c
);

  localparam int unsigned   CW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [LENGTH*BITS-1:0]   data_q, data_d;
  logic                     busy;
  logic                     at_last;
  logic                     hs;
  logic [BITS-1:0]          elem;

  assign busy     = (state_q == STREAM);
  assign at_last  = (count_q == LAST);
  // Ready depends only on registered state and reset, never on in_valid.
  assign in_ready = rst_n && (!busy || at_last);
  assign hs       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          data_d  = a;
          count_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!at_last) begin
          count_d = count_q + CW'(1);
        end else if (hs) begin
          // Final beat doubles as the load slot for the next vector.
          data_d  = a;
          count_d = '0;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (count_q == CW'(i)) begin
        elem = data_q[i*BITS +: BITS];
      end
    end
  end

  assign out_valid = busy;
  assign out_first = busy && (count_q == '0);
  assign out_last  = busy && at_last;
  assign c         = busy ? elem : '0;

endmodule

// File: tb/tb_stream_serialize.sv
// Self-checking bench for stream_serialize: LENGTH=4, LENGTH=1 and a LENGTH=10
// instance whose burst is summed the way the downstream accumulator would.
module tb_stream_serialize;

  typedef struct packed {
    logic [7:0] c;
    logic       f;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic        iv4 = 1'b0, rdy4, ov4, of4, ol4;
  logic [31:0] a4 = '0;
  logic [7:0]  c4;
  logic        iv1 = 1'b0, rdy1, ov1, of1, ol1;
  logic [7:0]  a1 = '0;
  logic [7:0]  c1;
  logic        iv10 = 1'b0, rdy10, ov10, of10, ol10;
  logic [79:0] a10 = '0;
  logic [7:0]  c10;

  beat_t q4[$];
  beat_t q1[$];
  logic  m_busy = 1'b0;
  int    m_cnt  = 0;

  always #5 clk = ~clk;

  stream_serialize #(.BITS(8), .LENGTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .a(a4),
    .out_valid(ov4), .out_first(of4), .out_last(ol4), .c(c4)
  );
  stream_serialize #(.BITS(8), .LENGTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .a(a1),
    .out_valid(ov1), .out_first(of1), .out_last(ol1), .c(c1)
  );
  stream_serialize #(.BITS(8), .LENGTH(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(rdy10), .a(a10),
    .out_valid(ov10), .out_first(of10), .out_last(ol10), .c(c10)
  );

  // Reference handshake model for the LENGTH=4 instance; pushes expected beats.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      q4.delete();
      q1.delete();
    end else begin
      if (m_busy && m_cnt != 3) begin
        m_cnt = m_cnt + 1;
      end else if (iv4) begin
        for (int i = 0; i < 4; i++) begin
          q4.push_back('{c: a4[i*8 +: 8], f: (i == 0), l: (i == 3)});
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end else begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end
      if (iv1) q1.push_back('{c: a1, f: 1'b1, l: 1'b1});
    end
  end

  always @(negedge clk) begin
    beat_t e;
    logic  exp_rdy;
    exp_rdy = rst_n && (!m_busy || m_cnt == 3);
    checks++;
    if (rdy4 !== exp_rdy) begin
      failures++;
      $display("FAIL sb4_in_ready got=%b want=%b t=%0t", rdy4, exp_rdy, $time);
    end
    checks++;
    if (ov4) begin
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL sb4_unexpected_beat got c=%h want no beat t=%0t", c4, $time);
      end else begin
        e = q4.pop_front();
        if ({c4, of4, ol4} !== e) begin
          failures++;
          $display("FAIL sb4_beat got c=%h f=%b l=%b want c=%h f=%b l=%b t=%0t",
                   c4, of4, ol4, e.c, e.f, e.l, $time);
        end
      end
    end else if ({c4, of4, ol4} !== 10'b0) begin
      failures++;
      $display("FAIL sb4_idle_outputs got c=%h f=%b l=%b want 0 t=%0t", c4, of4, ol4, $time);
    end
    checks++;
    if (ov1) begin
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb1_unexpected_beat got c=%h want no beat t=%0t", c1, $time);
      end else begin
        e = q1.pop_front();
        if ({c1, of1, ol1} !== e) begin
          failures++;
          $display("FAIL sb1_beat got c=%h f=%b l=%b want c=%h f=%b l=%b t=%0t",
                   c1, of1, ol1, e.c, e.f, e.l, $time);
        end
      end
    end else if ({c1, of1, ol1} !== 10'b0) begin
      failures++;
      $display("FAIL sb1_idle_outputs got c=%h f=%b l=%b want 0 t=%0t", c1, of1, ol1, $time);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({rdy4, ov4, of4, ol4, c4} !== 12'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b f=%b l=%b c=%h want all 0",
               rdy4, ov4, of4, ol4, c4);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({rdy4, rdy1, rdy10} !== 3'b111) begin
      failures++;
      $display("FAIL reset_release_ready got %b want 111", {rdy4, rdy1, rdy10});
    end
  endtask

  task automatic test_single();
    a4  = 32'h04030201;
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ov4, c4, of4, ol4, rdy4} !== {1'b1, 8'(k + 1), k == 0, k == 3, k == 3}) begin
        failures++;
        $display("FAIL single_beat%0d got v=%b c=%h f=%b l=%b rdy=%b want c=%h",
                 k, ov4, c4, of4, ol4, rdy4, k + 1);
      end
      step();
    end
    checks++;
    if ({ov4, c4, rdy4} !== {1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL single_after got v=%b c=%h rdy=%b want v=0 c=00 rdy=1", ov4, c4, rdy4);
    end
  endtask

  task automatic test_back_to_back();
    a4  = 32'h04030201;
    iv4 = 1'b1;
    step();
    a4 = 32'h08070605;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({ov4, c4, rdy4} !== {1'b1, 8'(i + 1), i == 3 || i == 7}) begin
        failures++;
        $display("FAIL b2b_beat%0d got v=%b c=%h rdy=%b want v=1 c=%h rdy=%b",
                 i, ov4, c4, rdy4, i + 1, i == 3 || i == 7);
      end
      if (i == 3) begin
        step();
        iv4 = 1'b0;
      end else begin
        step();
      end
    end
    checks++;
    if ({ov4, rdy4} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_after got v=%b rdy=%b want v=0 rdy=1", ov4, rdy4);
    end
  endtask

  task automatic test_held_request();
    a4  = 32'h0D0C0B0A;
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({c4, rdy4} !== {8'(8'h0A + k), k == 3}) begin
        failures++;
        $display("FAIL held_beat%0d got c=%h rdy=%b want c=%h rdy=%b",
                 k, c4, rdy4, 8'h0A + k, k == 3);
      end
      if (k == 0) begin
        step();
        iv4 = 1'b1;
        a4  = 32'h17161514;
      end else begin
        step();
      end
    end
    iv4 = 1'b0;
    checks++;
    if ({ov4, of4, c4} !== {1'b1, 1'b1, 8'h14}) begin
      failures++;
      $display("FAIL held_chain got v=%b f=%b c=%h want v=1 f=1 c=14", ov4, of4, c4);
    end
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (ov4 !== 1'b0) begin
      failures++;
      $display("FAIL held_drain got v=%b want 0", ov4);
    end
  endtask

  task automatic test_reset_mid_burst();
    a4  = 32'h34333231;
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    step();
    rst_n = 1'b0;
    iv4   = 1'b1;
    a4    = 32'h44434241;
    #1;
    checks++;
    if (rdy4 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ready_low got %b want 0", rdy4);
    end
    step();
    checks++;
    if ({ov4, of4, ol4, c4} !== 11'b0) begin
      failures++;
      $display("FAIL midrst_truncate got v=%b f=%b l=%b c=%h want 0", ov4, of4, ol4, c4);
    end
    rst_n = 1'b1;
    iv4   = 1'b0;
    #1;
    checks++;
    if (rdy4 !== 1'b1) begin
      failures++;
      $display("FAIL midrst_release_ready got %b want 1", rdy4);
    end
    step();
    checks++;
    if (ov4 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ignored_valid got v=%b want 0", ov4);
    end
    a4  = 32'h54535251;
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    checks++;
    if ({ov4, of4, c4} !== {1'b1, 1'b1, 8'h51}) begin
      failures++;
      $display("FAIL midrst_restart got v=%b f=%b c=%h want v=1 f=1 c=51", ov4, of4, c4);
    end
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_length1();
    logic [7:0] vals [3];
    vals[0] = 8'd9;
    vals[1] = 8'd10;
    vals[2] = 8'd11;
    iv1 = 1'b1;
    a1  = vals[0];
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) a1 = vals[i+1];
      else iv1 = 1'b0;
      checks++;
      if ({ov1, of1, ol1, c1, rdy1} !== {3'b111, vals[i], 1'b1}) begin
        failures++;
        $display("FAIL len1_beat%0d got v=%b f=%b l=%b c=%0d rdy=%b want c=%0d f=l=1",
                 i, ov1, of1, ol1, c1, rdy1, vals[i]);
      end
    end
    step();
    checks++;
    if ({ov1, c1, rdy1} !== {1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL len1_after got v=%b c=%h rdy=%b want v=0 c=00 rdy=1", ov1, c1, rdy1);
    end
  endtask

  task automatic test_loopback();
    int sum   = 0;
    int beats = 0;
    int firsts = 0;
    int lasts = 0;
    for (int i = 0; i < 10; i++) a10[i*8 +: 8] = 8'(i + 1);
    iv10 = 1'b1;
    step();
    iv10 = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (ov10) begin
        sum   += int'(c10);
        beats++;
        if (of10) firsts++;
        if (ol10) lasts++;
      end
      step();
    end
    checks++;
    if (sum !== 55 || beats !== 10 || firsts !== 1 || lasts !== 1) begin
      failures++;
      $display("FAIL loopback got sum=%0d beats=%0d firsts=%0d lasts=%0d want 55/10/1/1",
               sum, beats, firsts, lasts);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_held_request();
    test_reset_mid_burst();
    test_length1();
    test_loopback();
    step();
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got q4=%0d q1=%0d want 0/0", q4.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
